// File: rtl/regfile_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_sb : register file with per-register busy (scoreboard) bits
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(NREG)-1:0]  waddr,
   input  logic [XLEN-1:0]          wdata,
   input  logic [$clog2(NREG)-1:0]  ra1,
   input  logic [$clog2(NREG)-1:0]  ra2,
   output logic [XLEN-1:0]          rd1,
   output logic [XLEN-1:0]          rd2,
   output logic                     busy1,
   output logic                     busy2,
   input  logic                     rsv_en,
   input  logic [$clog2(NREG)-1:0]  rsv_addr,
   output logic                     rsv_ok,
   input  logic                     flush,
   output logic [$clog2(NREG):0]    busy_cnt
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] mem_q [NREG];
   logic [XLEN-1:0] mem_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     busy_cnt_q, busy_cnt_d;
   logic            wr_hit;

   assign wr_hit = we && (waddr != '0);

   // A writeback landing on the same cycle frees the register it targets.
   always_comb begin
      rsv_ok = 1'b0;
      if (!rst && rsv_en && !flush) begin
         rsv_ok = (rsv_addr == '0) || !busy_q[rsv_addr] || (we && (waddr == rsv_addr));
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_hit) begin
         mem_d[waddr] = wdata;
      end
   end

   // Clear-on-writeback first so a same-index reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_hit) begin
         busy_d[waddr] = 1'b0;
      end
      if (flush) begin
         busy_d = '0;
      end else if (rsv_ok && (rsv_addr != '0)) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < NREG; i++) begin
         busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   always_comb begin
      rd1   = mem_q[ra1];
      busy1 = busy_q[ra1];
      if ((BYPASS != 0) && we && (waddr == ra1)) begin
         rd1   = wdata;
         busy1 = 1'b0;
      end
      if (rst || (ra1 == '0)) begin
         rd1   = '0;
         busy1 = 1'b0;
      end
   end

   always_comb begin
      rd2   = mem_q[ra2];
      busy2 = busy_q[ra2];
      if ((BYPASS != 0) && we && (waddr == ra2)) begin
         rd2   = wdata;
         busy2 = 1'b0;
      end
      if (rst || (ra2 == '0)) begin
         rd2   = '0;
         busy2 = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_sb : directed self-checking bench for regfile_sb (bypass + no-bypass)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [XLEN-1:0] wdata;
   logic [AW-1:0]   ra1, ra2;
   logic            rsv_en;
   logic [AW-1:0]   rsv_addr;
   logic            flush;

   logic [XLEN-1:0] rd1, rd2, nb_rd1, nb_rd2;
   logic            busy1, busy2, nb_busy1, nb_busy2;
   logic            rsv_ok, nb_rsv_ok;
   logic [AW:0]     busy_cnt, nb_busy_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
      .flush(flush), .busy_cnt(busy_cnt)
   );

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2), .busy1(nb_busy1), .busy2(nb_busy2),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
      .flush(flush), .busy_cnt(nb_busy_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0;
      rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      ra1 = '0; ra2 = '0;

      // Inputs active during reset must be ignored
      we = 1'b1; waddr = 5'd5; wdata = 32'h0BAD_0BAD; ra1 = 5'd5;
      rsv_en = 1'b1; rsv_addr = 5'd2;
      #3;
      check("rst_rd1", rd1, 0);
      check("rst_busy1", busy1, 0);
      check("rst_rsv_ok", rsv_ok, 0);
      check("rst_busy_cnt", busy_cnt, 0);
      tick();
      rst = 1'b0;
      idle();
      #1;
      check("rst_mem5", rd1, 0);
      check("post_rst_cnt", busy_cnt, 0);

      // Plain write and read, register 0 stays zero
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; ra1 = '0;
      tick();
      idle(); ra1 = 5'd5;
      #1;
      check("wr5_rd1", rd1, 32'hDEAD_BEEF);
      check("wr5_busy1", busy1, 0);
      check("wr5_nb_rd1", nb_rd1, 32'hDEAD_BEEF);
      we = 1'b1; waddr = '0; wdata = 32'h1234;
      tick();
      idle(); ra2 = '0;
      #1;
      check("r0_rd2", rd2, 0);
      check("r0_nb_rd2", nb_rd2, 0);

      // Bypass versus stored value
      we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111;
      tick();
      we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; ra1 = 5'd7;
      #1;
      check("byp_rd1", rd1, 32'hA5A5_A5A5);
      check("byp_busy1", busy1, 0);
      check("nobyp_rd1", nb_rd1, 32'h1111_1111);
      tick();
      idle();
      #1;
      check("nobyp_rd1_next", nb_rd1, 32'hA5A5_A5A5);

      // Reserve, double reserve, writeback
      rsv_en = 1'b1; rsv_addr = 5'd3; ra1 = 5'd3;
      #1;
      check("rsv3_ok", rsv_ok, 1);
      tick();
      check("rsv3_busy1", busy1, 1);
      check("rsv3_cnt", busy_cnt, 1);
      check("rsv3_again_ok", rsv_ok, 0);
      tick();
      check("rsv3_rej_cnt", busy_cnt, 1);
      idle();
      we = 1'b1; waddr = 5'd3; wdata = 32'h33; ra1 = 5'd3;
      #1;
      check("wb3_byp_busy1", busy1, 0);
      check("wb3_nb_busy1", nb_busy1, 1);
      tick();
      idle();
      #1;
      check("wb3_busy1", busy1, 0);
      check("wb3_cnt", busy_cnt, 0);
      check("wb3_rd1", rd1, 32'h33);

      // Same-edge reserve and writeback on a busy register
      rsv_en = 1'b1; rsv_addr = 5'd9;
      tick();
      check("rsv9_cnt", busy_cnt, 1);
      we = 1'b1; waddr = 5'd9; wdata = 32'h55;
      #1;
      check("rsvwb9_ok", rsv_ok, 1);
      tick();
      idle(); ra1 = 5'd9;
      #1;
      check("rsvwb9_rd1", rd1, 32'h55);
      check("rsvwb9_busy1", busy1, 1);
      check("rsvwb9_cnt", busy_cnt, 1);
      we = 1'b1; waddr = 5'd9; wdata = 32'h55;
      tick();
      idle();
      #1;
      check("wb9_cnt", busy_cnt, 0);

      // Fill several, reserve r0, then flush
      rsv_en = 1'b1; rsv_addr = 5'd1; tick();
      rsv_addr = 5'd2; tick();
      rsv_addr = 5'd4; tick();
      check("rsv124_cnt", busy_cnt, 3);
      rsv_addr = '0;
      #1;
      check("rsv0_ok", rsv_ok, 1);
      tick();
      check("rsv0_cnt", busy_cnt, 3);
      flush = 1'b1; rsv_addr = 5'd6;
      we = 1'b1; waddr = 5'd10; wdata = 32'h0000_CAFE;
      #1;
      check("flush_rsv_ok", rsv_ok, 0);
      tick();
      idle(); ra1 = 5'd5; ra2 = 5'd10;
      #1;
      check("flush_cnt", busy_cnt, 0);
      check("flush_rd1", rd1, 32'hDEAD_BEEF);
      check("flush_wr_rd2", rd2, 32'h0000_CAFE);
      ra1 = 5'd4;
      #1;
      check("flush_busy1", busy1, 0);

      // Mid-cycle reset with state present
      rsv_en = 1'b1; rsv_addr = 5'd1; tick();
      rsv_addr = 5'd2; tick();
      check("pre_rst_cnt", busy_cnt, 2);
      ra1 = 5'd5; ra2 = 5'd10;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_rd1", rd1, 0);
      check("mid_rst_rd2", rd2, 0);
      check("mid_rst_cnt", busy_cnt, 0);
      check("mid_rst_rsv_ok", rsv_ok, 0);
      tick();
      rst = 1'b0;
      rsv_en = 1'b1; rsv_addr = 5'd1;
      #1;
      check("post_rst_rsv_ok", rsv_ok, 1);
      tick();
      idle(); ra1 = 5'd1; ra2 = 5'd5;
      #1;
      check("post_rst_rsv_cnt", busy_cnt, 1);
      check("post_rst_busy1", busy1, 1);
      check("post_rst_rd2", rd2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, register count (power of two, >=2); AW = clog2(NREG).
REQ-003 Parameter BYPASS, default 1, enables write-to-read forwarding when 1.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 we  in  1  writeback enable.
REQ-007 waddr  in  AW  writeback register index.
REQ-008 wdata  in  XLEN  writeback data.
REQ-009 ra1, ra2  in  AW each  read port indices.
REQ-010 rd1, rd2  out  XLEN each  read data.
REQ-011 busy1, busy2  out  1 each  pending-write flag for ra1/ra2.
REQ-012 rsv_en  in  1  request to reserve a destination register.
REQ-013 rsv_addr  in  AW  destination index to reserve.
REQ-014 rsv_ok  out  1  reservation accepted this cycle.
REQ-015 flush  in  1  synchronous clear of all busy bits.
REQ-016 busy_cnt  out  AW+1  number of registers currently busy.

Function
REQ-017 Storage: NREG x XLEN data array plus NREG busy bits; register 0 reads 0 and is never busy.
REQ-018 Write: on clk edge with we=1 and waddr!=0, reg[waddr] <= wdata and busy[waddr] <= 0 (unless REQ-024 applies); writes to index 0 ignored.
REQ-019 Read: rd1/rd2 combinational, 0 latency; rdN = 0 when raN=0.
REQ-020 Bypass: BYPASS=1, we=1, waddr=raN!=0 -> rdN = wdata same cycle; BYPASS=0 -> rdN = stored value (new value visible next cycle).
REQ-021 busyN = busy[raN], forced 0 when raN=0, and forced 0 when BYPASS=1, we=1, waddr=raN.
REQ-022 rsv_ok (combinational) = rsv_en & !flush & (rsv_addr=0 | !busy[rsv_addr] | (we & waddr=rsv_addr)).
REQ-023 Accepted reservation with rsv_addr!=0 sets busy[rsv_addr] on the edge; rsv_addr=0 accepted, no state change.
REQ-024 Same edge, same nonzero index, accepted reserve and writeback: data written, busy bit ends 1 (reserve wins).
REQ-025 Reserve on busy register without matching writeback: rsv_ok=0, no state change (caller stalls).
REQ-026 flush=1: all busy bits 0 on the edge; data writes in the same cycle still performed; reservations rejected.
REQ-027 busy_cnt is registered population count of busy bits, consistent with busy state after each edge; range 0..NREG-1.
REQ-028 Writeback to non-busy register legal: data written, busy stays 0.

Reset
REQ-029 rst=1 asynchronously clears all data registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-030 During rst, we/rsv_en/flush ignored; rsv_ok=0; rd1/rd2=0; busy1/busy2=0.
REQ-031 Reset deasserted mid-operation: first edge after release behaves normally; no pending reservation survives.

Verification
REQ-032 Reset then write reg5=0xDEADBEEF, next cycle ra1=5 -> rd1=0xDEADBEEF, busy1=0; write reg0=0x1234 -> ra2=0 reads 0.
REQ-033 Bypass: BYPASS=1, we=1, waddr=7, wdata=0xA5A5A5A5, ra1=7 same cycle -> rd1=0xA5A5A5A5, busy1=0; BYPASS=0 -> rd1=old value.
REQ-034 Reserve reg3 (rsv_ok=1) -> busy1=1 for ra1=3, busy_cnt=1; second reserve reg3 -> rsv_ok=0; writeback reg3 -> busy 0, busy_cnt=0.
REQ-035 Same edge: reserve reg9 (busy) and writeback reg9=0x55 -> rsv_ok=1; after edge reg9=0x55, busy[9]=1, busy_cnt unchanged.
REQ-036 Reserve regs 1,2,4 -> busy_cnt=3; flush with rsv_en=1 -> rsv_ok=0, after edge busy_cnt=0, data unchanged.
REQ-037 Assert rst mid-cycle with regs written/busy -> immediately rd1=rd2=0, busy_cnt=0; after release reserve reg1 -> rsv_ok=1.
